// File: rtl/tweakram_pkg.sv
// rtl/tweakram_pkg.sv - shared controller state type and read-during-write mode constants
package tweakram_pkg;

  typedef enum logic {
    FILL = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/tweakram_lane.sv
// rtl/tweakram_lane.sv - one byte lane of storage: a single write port and two asynchronous read ports
module tweakram_lane #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [7:0]            rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [7:0]            rdata_b
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  // Contents deliberately carry no reset; initialisation is the fill engine's job.
  logic [7:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/tweakram_dp.sv
// rtl/tweakram_dp.sv - dual-port byte-enabled RAM with a clear/fill engine and registered read outputs
module tweakram_dp
  import tweakram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_ack,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_re,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fill_ptr_q, fill_ptr_d;
  logic                    a_ack_q, a_ack_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic                    b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;

  logic                    filling;
  logic                    access_ok;
  logic                    a_fire;
  logic                    a_wr;
  logic                    b_fire;
  logic [NUM_LANES-1:0]    lane_we;
  logic [ADDR_WIDTH-1:0]   lane_waddr;
  logic [DATA_WIDTH-1:0]   lane_wdata;
  logic [DATA_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_b;
  logic [DATA_WIDTH-1:0]   merged_b;

  // Ports are locked out for the whole fill and in any cycle that (re)starts one.
  assign filling    = (state_q == FILL);
  assign access_ok  = (state_q == IDLE) && !clear;
  assign a_fire     = access_ok && a_req;
  assign a_wr       = a_fire && a_we;
  assign b_fire     = access_ok && b_re;
  assign lane_waddr = filling ? fill_ptr_q : a_addr;
  assign lane_wdata = filling ? INIT_VALUE : a_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i]          = filling || (a_wr && a_be[i]);
    assign merged_b[i*8 +: 8]  = a_be[i] ? a_wdata[i*8 +: 8] : rd_b[i*8 +: 8];

    tweakram_lane #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk     (clk),
      .we      (lane_we[i]),
      .waddr   (lane_waddr),
      .wdata   (lane_wdata[i*8 +: 8]),
      .raddr_a (a_addr),
      .rdata_a (rd_a[i*8 +: 8]),
      .raddr_b (b_addr),
      .rdata_b (rd_b[i*8 +: 8])
    );
  end

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    unique case (state_q)
      FILL: begin
        if (clear) begin
          fill_ptr_d = '0;
        end else begin
          fill_ptr_d = fill_ptr_q + ADDR_WIDTH'(1);
          if (fill_ptr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (clear) begin
          state_d    = FILL;
          fill_ptr_d = '0;
        end
      end
      default: begin
        state_d    = FILL;
        fill_ptr_d = '0;
      end
    endcase
  end

  always_comb begin
    a_ack_d    = a_fire;
    a_rdata_d  = (a_fire && !a_we) ? rd_a : a_rdata_q;
    b_rvalid_d = b_fire;
    b_rdata_d  = b_rdata_q;
    if (b_fire) begin
      // rd_b is the pre-write word; the merge only matters on an address collision.
      if (RDW_MODE == RDW_NEW && a_wr && a_addr == b_addr) begin
        b_rdata_d = merged_b;
      end else begin
        b_rdata_d = rd_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      fill_ptr_q <= '0;
      a_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      a_ack_q    <= a_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign busy     = (state_q == FILL);
  assign a_ack    = a_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;

endmodule
